// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
// Holds the FSM state encoding, the default hold limit and the index encoders.
package mux_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int MAX_HOLD_DEFAULT = 8;

    typedef logic [1:0] idx_t;

    // The mux select is declared [0:1], so SEL[0] carries the index LSB.
    function automatic logic [0:1] idx_to_sel(input idx_t idx);
        logic [0:1] sel;
        sel[0] = idx[0];
        sel[1] = idx[1];
        return sel;
    endfunction

    function automatic logic [0:3] idx_to_onehot(input idx_t idx);
        logic [0:3] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux_4_arbiter_if.sv
// Request/grant bundle between the requesters, the arbiter and the shared 4:1 mux.
// The arbiter sits on the slave side; the requester side drives REQ.
interface mux_4_arbiter_if;

    logic [0:3] REQ;
    logic [0:3] GNT;
    logic [0:1] SEL;
    logic       BUSY;

    modport master (
        output REQ,
        input  GNT,
        input  SEL,
        input  BUSY
    );

    modport slave (
        input  REQ,
        output GNT,
        output SEL,
        output BUSY
    );

endinterface

// File: rtl/rr_pick_4.sv
// Combinational circular priority search over four requesters.
// Scans start_i, start_i+1, start_i+2, start_i+3 (mod 4) and reports the first hit.
module rr_pick_4
    import mux_arb_pkg::*;
(
    input  logic [0:3] req_i,
    input  idx_t       start_i,
    output logic       found_o,
    output idx_t       idx_o
);

    always_comb begin
        idx_t cand;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        found_o = |req_i;
        idx_o   = start_i;
        cand    = start_i;
        // Walk from the farthest offset back to the nearest so the nearest hit wins.
        for (int off = 3; off >= 0; off--) begin
            cand = start_i + idx_t'(off);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/mux_4_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux with a bounded hold time under contention.
// All outputs are registered; SEL drives the existing mux select directly.
module mux_4_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    mux_4_arbiter_if.slave  bus
);

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    arb_state_e state_q;
    logic [0:3] gnt_q;
    logic [0:1] sel_q;
    logic       busy_q;
    idx_t       ptr_q;
    idx_t       owner_q;
    logic [3:0] cnt_q;

    logic [0:3] pick_mask;
    logic       pick_found;
    idx_t       pick_idx;

    logic       take_grant;
    logic       hold_inc;
    logic       go_idle;

    // While granted, the owner is masked out so "found" means someone else is waiting.
    always_comb begin
        pick_mask = bus.REQ;
        if (state_q == ST_GRANT) begin
            pick_mask = bus.REQ & ~idx_to_onehot(owner_q);
        end
    end

    // PTR always equals owner+1 while granted, so one search serves idle, release and timeout.
    rr_pick_4 u_pick (
        .req_i   (pick_mask),
        .start_i (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        take_grant = 1'b0;
        hold_inc   = 1'b0;
        go_idle    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                take_grant = pick_found;
            end
            ST_GRANT: begin
                if (bus.REQ[owner_q]) begin
                    if (cnt_q != HOLD_LAST) begin
                        hold_inc = 1'b1;
                    end else begin
                        // Timeout rotates only when someone else waits; otherwise CNT saturates.
                        take_grant = pick_found;
                    end
                end else begin
                    take_grant = pick_found;
                    go_idle    = !pick_found;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else if (take_grant) begin
            state_q <= ST_GRANT;
            owner_q <= pick_idx;
            gnt_q   <= idx_to_onehot(pick_idx);
            sel_q   <= idx_to_sel(pick_idx);
            busy_q  <= 1'b1;
            ptr_q   <= pick_idx + idx_t'(1);
            cnt_q   <= '0;
        end else if (hold_inc) begin
            cnt_q   <= cnt_q + 4'd1;
        end else if (go_idle) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end
    end

    assign bus.GNT  = gnt_q;
    assign bus.SEL  = sel_q;
    assign bus.BUSY = busy_q;

endmodule

// File: tb/tb_mux_4_arbiter.sv
// Self-checking bench for mux_4_arbiter: per-cycle expectations are queued as
// stimulus is applied and popped when the registered outputs settle.
module tb_mux_4_arbiter;

    logic CLK;
    logic RST;

    mux_4_arbiter_if bus();
    mux_4_arbiter_if bus1();

    mux_4_arbiter u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    mux_4_arbiter #(.MAX_HOLD(1)) u_dut_h1 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [6:0] exp_q[$];
    int checks;
    int failures;

    // Expected {GNT[0:3], SEL[0:1], BUSY} for a grant to index idx.
    function automatic logic [6:0] exp_grant(input int idx);
        logic [0:3] g;
        logic [0:1] s;
        g      = 4'b0000;
        g[idx] = 1'b1;
        s[0]   = idx[0];
        s[1]   = idx[1];
        return {g, s, 1'b1};
    endfunction

    function automatic logic [6:0] exp_idle(input logic [0:1] s);
        return {4'b0000, s, 1'b0};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST      = 1'b1;
        bus.REQ  = 4'b0000;
        bus1.REQ = 4'b0000;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] got, want;
        for (int c = 0; c < 2; c++) begin
            RST     = 1'b1;
            bus.REQ = 4'b1111;
            exp_q.push_back(exp_idle(2'b00));
            tick();
            got  = {bus.GNT, bus.SEL, bus.BUSY};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset cycle %0d: got gnt_sel_busy=%b required=%b", c, got, want);
            end
        end
        RST = 1'b0;
    endtask

    task automatic test_rotation();
        logic [6:0] got, want;
        do_reset();
        for (int c = 0; c < 34; c++) begin
            bus.REQ = 4'b1111;
            exp_q.push_back(exp_grant((c / 8) % 4));
            tick();
            got  = {bus.GNT, bus.SEL, bus.BUSY};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL rotation cycle %0d: got gnt_sel_busy=%b required=%b", c, got, want);
            end
        end
    endtask

    task automatic test_pulse();
        logic [6:0] got, want;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            bus.REQ = (c < 3) ? 4'b0010 : 4'b0000;
            exp_q.push_back((c < 3) ? exp_grant(2) : exp_idle(2'b01));
            tick();
            got  = {bus.GNT, bus.SEL, bus.BUSY};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL pulse cycle %0d: got gnt_sel_busy=%b required=%b", c, got, want);
            end
        end
    endtask

    task automatic test_handoff();
        logic [6:0] got, want;
        logic [0:3] reqs [7] = '{4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        logic [6:0] exps [7];
        exps = '{exp_grant(0), exp_grant(0), exp_grant(0), exp_grant(3), exp_grant(3),
                 exp_idle(2'b11), exp_idle(2'b11)};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            bus.REQ = reqs[c];
            exp_q.push_back(exps[c]);
            tick();
            got  = {bus.GNT, bus.SEL, bus.BUSY};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL handoff cycle %0d: got gnt_sel_busy=%b required=%b", c, got, want);
            end
        end
    endtask

    task automatic test_single_hold();
        logic [6:0] got, want;
        do_reset();
        // 20 cycles alone, then a second requester forces an immediate timeout rotation.
        for (int c = 0; c < 22; c++) begin
            bus.REQ = (c < 20) ? 4'b0100 : 4'b0110;
            exp_q.push_back((c < 20) ? exp_grant(1) : exp_grant(2));
            tick();
            got  = {bus.GNT, bus.SEL, bus.BUSY};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL single_hold cycle %0d: got gnt_sel_busy=%b required=%b", c, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [6:0] got, want;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            bus.REQ = 4'b1100;
            RST     = (c == 3);
            exp_q.push_back((c == 3) ? exp_idle(2'b00) : exp_grant(0));
            tick();
            got  = {bus.GNT, bus.SEL, bus.BUSY};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_mid_grant cycle %0d: got gnt_sel_busy=%b required=%b", c, got, want);
            end
        end
        RST = 1'b0;
    endtask

    task automatic test_max_hold_one();
        logic [6:0] got, want;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            bus1.REQ = 4'b1010;
            exp_q.push_back(exp_grant((c % 2 == 0) ? 0 : 2));
            tick();
            got  = {bus1.GNT, bus1.SEL, bus1.BUSY};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL max_hold_one cycle %0d: got gnt_sel_busy=%b required=%b", c, got, want);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RST      = 1'b1;
        bus.REQ  = 4'b0000;
        bus1.REQ = 4'b0000;
        test_reset();
        test_rotation();
        test_pulse();
        test_handoff();
        test_single_hold();
        test_reset_mid_grant();
        test_max_hold_one();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/mux_4_arbiter.md
MUX_4_ARBITER -- requirements
Module: mux_4_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, meaning: maximum consecutive grant cycles under contention; legal range 1..15.
REQ-002 CLK  input  1  rising-edge clock; the block SHALL use one clock.
REQ-003 RST  input  1  reset; SHALL be synchronous and active-high.
REQ-004 REQ  input  [0:3]  request from requester i, level-sensitive.
REQ-005 GNT  output  [0:3]  one-hot grant to requester i, or all-zero.
REQ-006 SEL  output  [0:1]  select for the shared 4:1 mux; SEL[0] = bit0 of owner index, SEL[1] = bit1 of owner index.
REQ-007 BUSY  output  1  high while any grant is active.

Function
REQ-008 The block SHALL implement states IDLE and GRANT; all outputs SHALL be registered.
REQ-009 GNT SHALL always be one-hot or zero; BUSY SHALL equal OR of GNT.
REQ-010 Round-robin pointer PTR (2 bits) SHALL name the highest-priority index; search order PTR, PTR+1, PTR+2, PTR+3 mod 4.
REQ-011 IDLE: if any REQ is high at edge k, GNT/SEL SHALL show the winner after edge k (1-cycle latency); the state SHALL become GRANT and the hold counter CNT SHALL clear to 0.
REQ-012 IDLE with no REQ: GNT=0000, BUSY=0, and SEL SHALL hold its last value.
REQ-013 On every new grant to index i, PTR SHALL become (i+1) mod 4.
REQ-014 GRANT, REQ[owner]=1, CNT<MAX_HOLD-1: grant SHALL hold and CNT SHALL increment.
REQ-015 GRANT, REQ[owner]=0: if another REQ is high, grant SHALL pass directly to the next requester after owner in circular order at the same edge with no idle bubble; otherwise the state SHALL become IDLE with GNT=0000.
REQ-016 GRANT, REQ[owner]=1, CNT=MAX_HOLD-1, another REQ high: grant SHALL rotate to the next requester after owner (forced timeout).
REQ-017 GRANT, REQ[owner]=1, CNT=MAX_HOLD-1, no other REQ: owner SHALL keep grant and CNT SHALL saturate.
REQ-018 Simultaneous owner drop and timeout: release rule REQ-015 SHALL apply.
REQ-019 MAX_HOLD=1 SHALL rotate every cycle under contention.
REQ-020 CNT SHALL be 4 bits; arithmetic SHALL never wrap.

Reset
REQ-021 RST=1 at an edge SHALL force state=IDLE, GNT=0000, SEL=00, BUSY=0, PTR=0, CNT=0, overriding all other conditions.
REQ-022 Reset asserted mid-grant SHALL drop the grant at that edge; the first post-reset arbitration SHALL start at index 0.

Structure
REQ-023 Package mux_arb_pkg SHALL hold the state enum, the MAX_HOLD default, and the index-to-SEL encoding function.
REQ-024 A combinational sub-module rr_pick_4 (inputs REQ mask and start index, outputs found flag and winner index) SHALL implement the circular priority search and be instantiated once.
REQ-025 SEL SHALL connect directly to the SEL port of the existing 4:1 mux; the arbiter SHALL contain no datapath.

Verification
REQ-026 Reset, then REQ=1111 held -> GNT=1000 (SEL=00) for 8 cycles, then 0100 (SEL=10) for 8 cycles, then 0010, then 0001, then 1000.
REQ-027 IDLE, REQ=0010 pulsed 3 cycles -> GNT=0010, SEL=01 one cycle later for 3 cycles, then GNT=0000, BUSY=0.
REQ-028 Owner 0 granted, REQ goes from 1000 to 0001 -> GNT=0001 at the next edge with no zero cycle.
REQ-029 REQ=0100 only, held 20 cycles -> GNT=0100 continuously, with no rotation and CNT saturated.
REQ-030 REQ=1100, RST asserted at cycle 4 of the grant to index 0 -> GNT=0000 at that edge; after RST drops -> GNT=1000.
REQ-031 MAX_HOLD=1, REQ=1010 -> GNT alternates 1000, 0010 every cycle.
